// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Pipelined WIDTH-bit, 8-function ALU with LC-3b condition codes
//            and signed-add overflow. Valid/ready handshake on both sides,
//            collapsing bubbles, synchronous flush for branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [2:0]       out_nzp,
    output logic             out_ovf
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_LSHF  = 3'b100;
    localparam logic [2:0] OP_RSHFL = 3'b101;
    localparam logic [2:0] OP_RSHFA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Stage registers: valid bit plus result, condition codes and overflow
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [2:0]        nzp_q [STAGES];
    logic [2:0]        nzp_d [STAGES];
    logic [STAGES-1:0] ovf_q, ovf_d;

    // Combinational compute on the offered operands
    logic [WIDTH-1:0]  res_w;
    logic [2:0]        nzp_w;
    logic              ovf_w;
    logic [SHW-1:0]    shamt_w;

    // Per-stage "can load this cycle" and the value each stage would load
    logic [STAGES-1:0] space_w;
    logic [STAGES-1:0] chain_vld_w;
    logic [WIDTH-1:0]  chain_res_w [STAGES];
    logic [2:0]        chain_nzp_w [STAGES];
    logic [STAGES-1:0] chain_ovf_w;
    logic              accept_w;

    assign shamt_w = in_b[SHW-1:0];

    // ALU function, condition codes and ADD overflow from the input operands
    always_comb begin
        res_w = '0;
        case (in_op)
            OP_ADD:   res_w = in_a + in_b;
            OP_AND:   res_w = in_a & in_b;
            OP_XOR:   res_w = in_a ^ in_b;
            OP_PASSA: res_w = in_a;
            OP_LSHF:  res_w = in_a << shamt_w;
            OP_RSHFL: res_w = in_a >> shamt_w;
            OP_RSHFA: res_w = $signed(in_a) >>> shamt_w;
            OP_PASSB: res_w = in_b;
            default:  res_w = '0;
        endcase
        nzp_w[2] = res_w[MSB];
        nzp_w[1] = (res_w == '0);
        nzp_w[0] = !res_w[MSB] && (res_w != '0);
        ovf_w    = (in_op == OP_ADD) && (in_a[MSB] == in_b[MSB])
                   && (res_w[MSB] != in_a[MSB]);
    end

    // Room propagates backwards: a stage can load if empty or if it drains
    always_comb begin
        logic room;
        space_w = '0;
        room    = !vld_q[LAST] || out_ready;
        space_w[LAST] = room;
        for (int i = LAST - 1; i >= 0; i--) begin
            room       = !vld_q[i] || room;
            space_w[i] = room;
        end
    end

    assign in_ready = !flush && space_w[0];
    assign accept_w = in_valid && in_ready;

    // Source of each stage: the ALU for stage 0, the previous stage otherwise
    always_comb begin
        chain_vld_w    = '0;
        chain_ovf_w    = '0;
        chain_vld_w[0] = accept_w;
        chain_res_w[0] = res_w;
        chain_nzp_w[0] = nzp_w;
        chain_ovf_w[0] = ovf_w;
        for (int i = 1; i < STAGES; i++) begin
            chain_vld_w[i] = vld_q[i-1];
            chain_res_w[i] = res_q[i-1];
            chain_nzp_w[i] = nzp_q[i-1];
            chain_ovf_w[i] = ovf_q[i-1];
        end
    end

    // Next state: load where there is room; data moves only with a valid op
    always_comb begin
        vld_d = vld_q;
        res_d = res_q;
        nzp_d = nzp_q;
        ovf_d = ovf_q;
        for (int i = 0; i < STAGES; i++) begin
            if (space_w[i]) begin
                vld_d[i] = chain_vld_w[i];
                if (chain_vld_w[i]) begin
                    res_d[i] = chain_res_w[i];
                    nzp_d[i] = chain_nzp_w[i];
                    ovf_d[i] = chain_ovf_w[i];
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                nzp_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            nzp_q <= nzp_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_res   = res_q[LAST];
    assign out_nzp   = nzp_q[LAST];
    assign out_ovf   = ovf_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Scoreboard bench for alu_pipe (16-bit/2-stage instance) plus a
//            directed 32-bit/1-stage instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_res;
    logic [2:0]   out_nzp;
    logic         out_ovf;

    logic         s_flush = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_a = '0;
    logic [31:0]  s_b = '0;
    logic [2:0]   s_op = '0;
    logic         s_ovalid;
    logic         s_ordy = 1'b1;
    logic [31:0]  s_res;
    logic [2:0]   s_nzp;
    logic         s_ovf;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_nzp(out_nzp), .out_ovf(out_ovf)
    );

    alu_pipe #(.WIDTH(32), .STAGES(1)) u_dut32 (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_a(s_a), .in_b(s_b), .in_op(s_op),
        .out_valid(s_ovalid), .out_ready(s_ordy),
        .out_res(s_res), .out_nzp(s_nzp), .out_ovf(s_ovf)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   nzp;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_stall = 0;
    logic         held_v = 1'b0;
    logic [W-1:0] held_res;
    logic [2:0]   held_nzp;
    logic         held_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU of width w: returns {ovf, N, Z, P, result[63:0]}
    function automatic logic [67:0] model(input int w, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic [2:0] op);
        logic [63:0] mask, a, b, r, ax;
        int          sh;
        logic        n, z, p, v;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        sh   = int'(b & 64'(w - 1));
        ax   = a[w-1] ? (a | ~mask) : a;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a & b;
            3'd2:    r = a ^ b;
            3'd3:    r = a;
            3'd4:    r = a << sh;
            3'd5:    r = a >> sh;
            3'd6:    r = 64'($signed(ax) >>> sh);
            default: r = b;
        endcase
        r = r & mask;
        n = r[w-1];
        z = (r == 64'd0);
        p = !n && !z;
        v = (op == 3'd0) && (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
        return {v, n, z, p, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each consumed output with the oldest expected entry
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_res", 64'(out_res), 64'(held_res));
                chk("stall_nzp", 64'(out_nzp), 64'(held_nzp));
                chk("stall_ovf", 64'(out_ovf), 64'(held_ovf));
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    chk("res", 64'(out_res), 64'(e.res));
                    chk("nzp", 64'(out_nzp), 64'(e.nzp));
                    chk("ovf", 64'(out_ovf), 64'(e.ovf));
                    if (last_stall < e.acc)
                        chk("latency", 64'(cyc - e.acc), 64'(S - 1));
                end
                if (!out_ready) begin
                    held_v   = 1'b1;
                    held_res = out_res;
                    held_nzp = out_nzp;
                    held_ovf = out_ovf;
                end
            end
            if (flush) begin
                sb.delete();
                held_v = 1'b0;
            end
            if (!out_ready || flush) last_stall = cyc;
        end
    end

    // One cycle of stimulus; checks in_ready against occupancy and logs accepts
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic ordy, input logic fl,
                         output logic acc);
        logic        exp_rdy;
        logic [67:0] m;
        exp_t        e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && ((sb.size() < S) || ordy);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc   = v && in_ready;
        m     = model(W, 64'(a), 64'(b), op);
        e.res = m[W-1:0];
        e.nzp = m[66:64];
        e.ovf = m[67];
        e.acc = cyc + 1;
        @(posedge clk);
        if (acc) sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) drive(1'b1, a, b, op, ordy, 1'b0, acc);
        if (!acc) begin
            errors++;
            $display("FAIL issue_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 3'd0, ordy, 1'b0, acc);
    endtask

    logic [W-1:0] ta [4] = '{16'h1111, 16'h2222, 16'h8000, 16'h00FF};
    logic [W-1:0] tb [4] = '{16'h0101, 16'h2020, 16'h8000, 16'h0003};
    logic [2:0]   to [4] = '{3'd0, 3'd2, 3'd0, 3'd4};

    initial begin
        logic        acc;
        int          idx;
        logic [67:0] m;

        // Reset state, checked while reset is still asserted
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(out_res), 64'd0);
        chk("rst_nzp", 64'(out_nzp), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_stall = cyc;
        #1;
        chk("rdy_after_rst", 64'(in_ready), 64'd1);

        // Back-to-back ops, no stall
        issue(16'h7FFF, 16'h0001, 3'd0, 1'b1);
        issue(16'hF0F0, 16'h0FF0, 3'd1, 1'b1);
        issue(16'hAAAA, 16'hAAAA, 3'd2, 1'b1);
        issue(16'h0000, 16'h1234, 3'd7, 1'b1);
        idle(4, 1'b1);

        // Shifts, including an amount field that wraps to zero
        issue(16'h8001, 16'h0004, 3'd4, 1'b1);
        issue(16'h8001, 16'h0004, 3'd5, 1'b1);
        issue(16'h8001, 16'h0004, 3'd6, 1'b1);
        issue(16'h8001, 16'h0010, 3'd6, 1'b1);
        issue(16'h8001, 16'h0010, 3'd4, 1'b1);
        idle(4, 1'b1);

        // Stall: 5 cycles with out_ready low, 4 ops offered
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, ta[idx], tb[idx], to[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_accepts", 64'(idx), 64'd2);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            drive(1'b1, ta[idx], tb[idx], to[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        idle(4, 1'b1);
        chk("stall_drained", 64'(sb.size()), 64'd0);

        // Flush with two ops in flight and a third offered
        issue(16'h0003, 16'h0004, 3'd0, 1'b0);
        issue(16'h0005, 16'h0006, 3'd1, 1'b0);
        drive(1'b1, 16'h00C3, 16'h0101, 3'd2, 1'b1, 1'b1, acc);
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        issue(16'h00C3, 16'h0101, 3'd2, 1'b1);
        idle(4, 1'b1);
        chk("flush_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset with two ops in flight
        issue(16'h1234, 16'h4321, 3'd0, 1'b0);
        issue(16'hFFFF, 16'h0F0F, 3'd1, 1'b0);
        idle(1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_res", 64'(out_res), 64'd0);
        chk("arst_nzp", 64'(out_nzp), 64'd0);
        sb.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_stall = cyc;
        idle(4, 1'b1);
        chk("arst_no_output", 64'(out_valid), 64'd0);

        // Randomized traffic with random back-pressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0), acc);
        end
        idle(S + 3, 1'b1);
        chk("random_drained", 64'(sb.size()), 64'd0);

        // 32-bit, single-stage instance: one-edge latency
        @(negedge clk);
        s_valid = 1'b1; s_a = 32'h7FFF_FFFF; s_b = 32'h1; s_op = 3'd0;
        #1;
        chk("w32_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m = model(32, 64'(32'h7FFF_FFFF), 64'd1, 3'd0);
        chk("w32_add_valid", 64'(s_ovalid), 64'd1);
        chk("w32_add_res", 64'(s_res), 64'(m[31:0]));
        chk("w32_add_nzp", 64'(s_nzp), 64'(m[66:64]));
        chk("w32_add_ovf", 64'(s_ovf), 64'(m[67]));
        @(negedge clk);
        s_valid = 1'b1; s_a = 32'h8000_0000; s_b = 32'd31; s_op = 3'd6;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m = model(32, 64'(32'h8000_0000), 64'd31, 3'd6);
        chk("w32_rshfa_valid", 64'(s_ovalid), 64'd1);
        chk("w32_rshfa_res", 64'(s_res), 64'(m[31:0]));
        chk("w32_rshfa_ovf", 64'(s_ovf), 64'(m[67]));
        @(posedge clk);
        #1;
        chk("w32_drained", 64'(s_ovalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
